// File: rtl/seq_wide_adder.sv
// seq_wide_adder: multi-cycle wide adder. Operands are latched on START and
// summed one word_width slice per clock (LS slice first) through a single
// carry-select slice adder (CSA_S), chaining the carry between slices.

// CSA_S: combinational carry-select adder of word_width bits built from
// unit_width ripple units, each precomputing its sum for carry-in 0 and 1.
module CSA_S #(
  parameter int word_width = 8,
  parameter int unit_width = 4
) (
  input  logic [word_width-1:0] A,
  input  logic [word_width-1:0] B,
  input  logic                  C_IN,
  output logic [word_width-1:0] R,
  output logic                  C_OUT
);

  localparam int NumUnits = word_width / unit_width;

  logic [NumUnits:0] carry;

  assign carry[0] = C_IN;

  for (genvar u = 0; u < NumUnits; u++) begin : g_unit
    logic [unit_width:0] sum0;
    logic [unit_width:0] sum1;

    assign sum0 = {1'b0, A[u*unit_width +: unit_width]}
                + {1'b0, B[u*unit_width +: unit_width]};
    assign sum1 = {1'b0, A[u*unit_width +: unit_width]}
                + {1'b0, B[u*unit_width +: unit_width]}
                + {{unit_width{1'b0}}, 1'b1};

    assign R[u*unit_width +: unit_width] =
      carry[u] ? sum1[unit_width-1:0] : sum0[unit_width-1:0];
    assign carry[u+1] = carry[u] ? sum1[unit_width] : sum0[unit_width];
  end

  assign C_OUT = carry[NumUnits];

endmodule

module seq_wide_adder #(
  parameter int word_width = 8,
  parameter int unit_width = 4,
  parameter int word_count = 4
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             START,
  input  logic                             C_IN,
  input  logic [word_width*word_count-1:0] A,
  input  logic [word_width*word_count-1:0] B,
  output logic [word_width*word_count-1:0] R,
  output logic                             C_OUT,
  output logic                             BUSY,
  output logic                             DONE
);

  localparam int W  = word_width * word_count;
  localparam int IW = (word_count > 1) ? $clog2(word_count) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(word_count - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    r_q, r_d;
  logic            cout_q, cout_d;

  logic [word_width-1:0] sliceA;
  logic [word_width-1:0] sliceB;
  logic [word_width-1:0] sliceSum;
  logic                  sliceCarry;

  // Select the operand slices addressed by the current slice index.
  always_comb begin
    sliceA = '0;
    sliceB = '0;
    for (int s = 0; s < word_count; s++) begin
      if (idx_q == IW'(s)) begin
        sliceA = a_q[s*word_width +: word_width];
        sliceB = b_q[s*word_width +: word_width];
      end
    end
  end

  CSA_S #(
    .word_width (word_width),
    .unit_width (unit_width)
  ) u_csa (
    .A     (sliceA),
    .B     (sliceB),
    .C_IN  (cy_q),
    .R     (sliceSum),
    .C_OUT (sliceCarry)
  );

  // Next-state logic: accept in IDLE/DONE, one slice per cycle in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          cy_d    = C_IN;
          r_d     = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int s = 0; s < word_count; s++) begin
          if (idx_q == IW'(s)) begin
            r_d[s*word_width +: word_width] = sliceSum;
          end
        end
        cy_d = sliceCarry;
        if (idx_q == LastIdx) begin
          cout_d  = sliceCarry;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cout_q  <= cout_d;
    end
  end

  assign R     = r_q;
  assign C_OUT = cout_q;
  assign BUSY  = (state_q == ST_RUN);
  assign DONE  = (state_q == ST_DONE);

endmodule
